// File: rtl/voice_scheduler_if.sv
// Signal bundle between the voice scheduler, the note decoder, the sine BRAM and the PWM stage.
// master = scheduler side, slave = surrounding logic.
interface voice_scheduler_if #(
    parameter int NUM_VOICES   = 4,
    parameter int PHASE_WIDTH  = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 8,
    parameter int MIX_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_VOICES)
);
    logic [NUM_VOICES-1:0]             voice_en_in;
    logic [NUM_VOICES*PHASE_WIDTH-1:0] phase_incr_in;
    logic [ADDR_WIDTH-1:0]             bram_addr_out;
    logic [SAMPLE_WIDTH-1:0]           bram_data_in;
    logic [MIX_WIDTH-1:0]              mix_out;
    logic                              mix_valid_out;

    modport master (
        input  voice_en_in, phase_incr_in, bram_data_in,
        output bram_addr_out, mix_out, mix_valid_out
    );

    modport slave (
        output voice_en_in, phase_incr_in, bram_data_in,
        input  bram_addr_out, mix_out, mix_valid_out
    );
endinterface

// File: rtl/voice_scheduler.sv
// Time-shares one sine-BRAM read port across NUM_VOICES phase accumulators and
// sums the returned samples into one mixed sample per sample tick.

module voice_phase #(
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   issue,
    input  logic                   en,
    input  logic [PHASE_WIDTH-1:0] incr,
    output logic [PHASE_WIDTH-1:0] phase
);
    // A disabled voice parks at phase 0 so re-enabling restarts the waveform.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)  phase <= '0;
        else if (issue) phase <= en ? phase + incr : '0;
    end
endmodule

module voice_scheduler #(
    parameter int NUM_VOICES    = 4,
    parameter int PHASE_WIDTH   = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int SAMPLE_WIDTH  = 8,
    parameter int BRAM_LATENCY  = 2,
    parameter int SAMPLE_PERIOD = 2268,
    parameter int MIX_WIDTH     = SAMPLE_WIDTH + $clog2(NUM_VOICES)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    voice_scheduler_if.master bus
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int LAT    = BRAM_LATENCY;
    localparam logic [MIX_WIDTH-1:0] MID     = MIX_WIDTH'(2 ** (SAMPLE_WIDTH - 1));
    localparam logic [MIX_WIDTH-1:0] RST_MIX = MIX_WIDTH'(NUM_VOICES * (2 ** (SAMPLE_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                                 state, nstate;
    logic [CNT_W-1:0]                       cnt;
    logic                                   tick;
    logic [VIDX_W-1:0]                      vidx, issue_idx;
    logic                                   issue, acc_clr, mix_valid;
    logic [NUM_VOICES-1:0]                  issue_sel;
    logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] incr, phase;
    logic [ADDR_WIDTH-1:0]                  addr;
    logic [LAT:0]                           vld_pipe, en_pipe, last_pipe;
    logic [MIX_WIDTH-1:0]                   acc, acc_next, exit_term, mix;
    logic                                   exit_vld, exit_last;

    assign incr = bus.phase_incr_in;

    // Free-running sample-rate counter; never stalled by the frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cnt <= '0;
        else           cnt <= tick ? '0 : cnt + 1'b1;
    end
    assign tick = (cnt == CNT_W'(SAMPLE_PERIOD - 1));

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_phase #(.PHASE_WIDTH(PHASE_WIDTH)) u_phase (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .issue    (issue_sel[v]),
            .en       (bus.voice_en_in[v]),
            .incr     (incr[v]),
            .phase    (phase[v])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:  if (tick) nstate = (NUM_VOICES == 1) ? DRAIN : ISSUE;
            ISSUE: if (vidx == VIDX_W'(NUM_VOICES - 1)) nstate = DRAIN;
            DRAIN: if (exit_last) nstate = DONE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Voice 0 is issued on the tick edge itself so its address is visible in T+1;
    // ISSUE then covers voices 1..NUM_VOICES-1.
    always_comb begin
        issue     = (state == IDLE && tick) || (state == ISSUE);
        issue_idx = (state == ISSUE) ? vidx : '0;
        acc_clr   = (state == IDLE && tick);
        mix_valid = (state == DONE);
        issue_sel = '0;
        if (issue) issue_sel[issue_idx] = 1'b1;
    end

    // Tag stage k lines up with the address issued k cycles earlier; stage LAT meets its data.
    assign exit_vld  = vld_pipe[LAT];
    assign exit_last = vld_pipe[LAT] & last_pipe[LAT];
    assign exit_term = en_pipe[LAT] ? MIX_WIDTH'(bus.bram_data_in) : MID;
    assign acc_next  = acc + exit_term;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vidx      <= '0;
            addr      <= '0;
            vld_pipe  <= '0;
            en_pipe   <= '0;
            last_pipe <= '0;
            acc       <= '0;
            mix       <= RST_MIX;
        end else begin
            if (issue) begin
                vidx <= issue_idx + VIDX_W'(1);
                addr <= phase[issue_idx][PHASE_WIDTH-1 -: ADDR_WIDTH];
            end
            vld_pipe  <= {vld_pipe[LAT-1:0],  issue};
            en_pipe   <= {en_pipe[LAT-1:0],   issue & bus.voice_en_in[issue_idx]};
            last_pipe <= {last_pipe[LAT-1:0], issue && (issue_idx == VIDX_W'(NUM_VOICES - 1))};
            if (acc_clr)       acc <= '0;
            else if (exit_vld) acc <= acc_next;
            // The final sample is folded straight into mix so it lands with the DONE pulse.
            if (exit_last) mix <= acc_next;
        end
    end

    assign bus.bram_addr_out = addr;
    assign bus.mix_out       = mix;
    assign bus.mix_valid_out = mix_valid;
endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Time-multiplexes one read port of the shared sine-wave BRAM across NUM_VOICES independent phase accumulators, giving polyphony with a single waveform table. On every sample tick it walks the voices in order, issues one BRAM address per voice, and accumulates the returned samples. It then presents one mixed sample per tick to the downstream scaling/PWM stage. It sits between the note decoding logic, which supplies per-voice enables and phase increments, and the sine BRAM plus PWM.

Parameters:
NUM_VOICES, 4, number of time-shared voices (>=1)
PHASE_WIDTH, 32, phase accumulator width in bits
ADDR_WIDTH, 8, BRAM address width; taken from phase[PHASE_WIDTH-1 -: ADDR_WIDTH]
SAMPLE_WIDTH, 8, BRAM data width, unsigned, midpoint = silence
BRAM_LATENCY, 2, cycles from address driven to data valid (output register enabled)
SAMPLE_PERIOD, 2268, clocks per output sample (100 MHz / ~44.1 kHz); must be > NUM_VOICES+BRAM_LATENCY+2
MIX_WIDTH, SAMPLE_WIDTH+$clog2(NUM_VOICES), derived mix width

Ports:
clk_in  input  1  system clock (100 MHz)
rst_n_in  input  1  asynchronous active-low reset
voice_en_in  input  NUM_VOICES  per-voice gate, bit v = voice v
phase_incr_in  input  NUM_VOICES*PHASE_WIDTH  voice v increment at bits [v*PHASE_WIDTH +: PHASE_WIDTH]
bram_addr_out  output  ADDR_WIDTH  registered BRAM port-A address
bram_data_in  input  SAMPLE_WIDTH  BRAM port-A read data
mix_out  output  MIX_WIDTH  registered sum of the last frame's voice samples
mix_valid_out  output  1  one-cycle pulse when mix_out updates

Behaviour:
- Reset (async assert, sync release): tick counter=0, all phases=0, state IDLE, bram_addr_out=0, mix_out=NUM_VOICES*2^(SAMPLE_WIDTH-1) (512 at defaults), mix_valid_out=0, accumulator and pipeline tags cleared.
- Tick counter: counts 0..SAMPLE_PERIOD-1 and wraps. The tick is the cycle with count==SAMPLE_PERIOD-1. First tick occurs SAMPLE_PERIOD-1 cycles after reset release.
- FSM states:
  - IDLE: on tick, go to ISSUE with voice index 0 and accumulator cleared to 0.
  - ISSUE: one voice per cycle, v=0..NUM_VOICES-1. bram_addr_out <= top ADDR_WIDTH bits of phase_v before update.
    - Enabled voice: phase_v <= phase_v + incr_v, mod 2^PHASE_WIDTH (natural wrap). The increment is sampled that cycle.
    - Disabled voice: phase_v <= 0, so a re-enabled voice restarts at phase 0.
    - After the last voice, go to DRAIN.
  - DRAIN: wait until the last tag exits the latency pipeline, then go to DONE.
  - DONE: mix_out <= accumulator; mix_valid_out=1 for exactly this cycle; go to IDLE.
- Latency pipeline: a BRAM_LATENCY-deep shift register of {valid, enable} tags, aligned with bram_addr_out. When a tag exits, bram_data_in is added to the accumulator if its enable bit is set; otherwise 2^(SAMPLE_WIDTH-1) is added.
- Timing: the address for voice v is driven in cycle T+1+v, where T is the tick cycle. mix_valid_out is high in cycle T+NUM_VOICES+BRAM_LATENCY+1 (T+7 at defaults).
- Accumulator is MIX_WIDTH wide, so no overflow is possible. Maximum is NUM_VOICES*(2^SAMPLE_WIDTH-1) = 1020.
- voice_en_in is sampled per voice in its ISSUE cycle. Changes mid-frame affect only voices not yet issued.
- bram_addr_out holds its last value outside ISSUE.
- A tick cannot arrive while busy, by the SAMPLE_PERIOD constraint. The counter runs freely and is never stalled.
- Reset mid-frame: all state is cleared immediately, no mix_valid_out pulse is produced, and timing restarts from counter 0.

Test Plan:
Bench BRAM model: 2-cycle latency, contents data[a]=a (ramp), SAMPLE_PERIOD=32 for sim.
1. Reset then release, all voices disabled -> mix_out=512, mix_valid_out pulses every 32 cycles, first pulse 31+7=38 cycles after release, mix_out stays 512.
2. Voice 0 enabled with incr=0x0100_0000, others off -> frame k gives mix_out = (k mod 256)+384. Frame 0 = 384, frame 255 = 639, frame 256 = 384 (wrap).
3. All four enabled with incr=0x0100_0000, 0x0200_0000, 0x0300_0000, 0x0400_0000 -> frame 0 = 0, frame 1 = 10, frame 2 = 20. bram_addr_out sequence in frame 1 is 1, 2, 3, 4 on cycles T+1..T+4.
4. BRAM forced to 255, all enabled -> mix_out=1020 with no wrap. Then disable voice 2 -> next frame 893, and voice 2's address returns to 0 when it is re-enabled.
5. Latency check: mix_valid_out exactly 7 cycles after the tick and one cycle wide. No bram_addr_out change in IDLE.
6. Deassert rst_n_in during the ISSUE of voice 2 -> outputs reset in the same cycle, no valid pulse for that frame. After release, the first pulse comes at +38 cycles with mix_out=512 for all voices disabled.
